dp_bram_clr: RTL and testbench
==============================

DP_BRAM_CLR -- requirements
Module: dp_bram_clr

Interface
REQ-001 The module SHALL have parameter CORE, default 0, meaning core index used only in debug output.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; it must be a multiple of 8.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 8, meaning address width; depth is 2^ADDR_WIDTH words.
REQ-004 The module SHALL have parameter READ_LATENCY, default 1, meaning read pipeline depth; legal values are 1 or 2.
REQ-005 The module SHALL have parameters WRITE_MODE_1 and WRITE_MODE_2, default 1, meaning same-port read-during-write mode: 0 = read-first, 1 = write-first.
REQ-006 The module SHALL have parameter PRIORITY_PORT, default 1, meaning which port wins overlapping-lane write collisions; legal values are 1 or 2.
REQ-007 The module SHALL have parameter CLEAR_ON_RESET, default 0, meaning that 1 zeroes the whole array after reset.
REQ-008 clock  input  1  single clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 readEnable_1, writeEnable_1  input  1 each  port-1 read and write requests.
REQ-011 address_1  input  ADDR_WIDTH  port-1 word address.
REQ-012 writeData_1  input  DATA_WIDTH; byteEnable_1  input  DATA_WIDTH/8  port-1 write data and lane enables.
REQ-013 readData_1  output  DATA_WIDTH; readValid_1  output  1  port-1 read data and its one-cycle valid strobe.
REQ-014 Port-2 signals SHALL mirror REQ-010 to REQ-013 with suffix _2.
REQ-015 collision  output  1  one-cycle pulse flagging an overlapping-lane dual write to the same address.
REQ-016 busy  output  1  high while the array clear is in progress.

Function
REQ-017 Writes SHALL update only the byte lanes whose byteEnable bit is 1; writeEnable with byteEnable all zero is a no-op.
REQ-018 A read accepted at edge N SHALL drive readData and a readValid pulse after edge N+READ_LATENCY-1; each read produces exactly one valid pulse.
REQ-019 readData SHALL hold its last value when no read completes.
REQ-020 Same-port read and write to the same address in one cycle SHALL return the old word in read-first mode and the lane-merged new word in write-first mode.
REQ-021 A read on one port and a write on the other to the same address in the same cycle SHALL return the old word.
REQ-022 When both ports write the same address, overlapping enabled lanes SHALL take PRIORITY_PORT data and non-overlapping lanes SHALL take their own port's data.
REQ-023 collision SHALL pulse high one cycle after a same-cycle dual write with nonzero (byteEnable_1 & byteEnable_2) at equal addresses; otherwise it is 0.
REQ-024 The FSM SHALL have two states, IDLE and CLEAR; reset enters CLEAR when CLEAR_ON_RESET=1, otherwise IDLE.
REQ-025 In CLEAR, one word per cycle SHALL be zeroed from address 0 upward; after address 2^ADDR_WIDTH-1 is zeroed the FSM enters IDLE; total duration is 2^ADDR_WIDTH cycles.
REQ-026 busy SHALL be 1 exactly while in CLEAR; port requests during CLEAR are ignored with no write, no readValid, and no collision.
REQ-027 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-028 The read pipeline SHALL be flushed by reset; in-flight reads produce no readValid.

Reset
REQ-029 While reset is high at a clock edge: readData_1/2 = 0, readValid_1/2 = 0, collision = 0, busy = CLEAR_ON_RESET, pipeline empty.
REQ-030 With CLEAR_ON_RESET=0, reset SHALL NOT alter array contents.

Verification
REQ-031 DATA_WIDTH=32, ADDR_WIDTH=4, READ_LATENCY=2: write 0xDEADBEEF to addr 3 on port 1, then read addr 3 on port 2 -> readData_2=0xDEADBEEF with readValid_2 two edges after the read request.
REQ-032 Addr 5 holds 0x11223344; port 1 writes 0xAABBCCDD with byteEnable 0101 -> subsequent read returns 0x11BB33DD.
REQ-033 PRIORITY_PORT=2; addr 7; port 1 writes 0x00000011 with be 0011; port 2 writes 0x22000022 with be 1001, same cycle -> word 0x22000022 in lanes 3,0 and 0x00 in lane 1 from port 1 (word 0x22000022); collision=1 next cycle.
REQ-034 WRITE_MODE_1=0 vs 1: addr 2 holds 0x5; port 1 reads and writes 0x9 at addr 2 in one cycle -> readData_1=0x5 in read-first, 0x9 in write-first.
REQ-035 CLEAR_ON_RESET=1 with the array prefilled: pulse reset -> busy high 16 cycles; reset again at cycle 8 -> busy for 16 more cycles; afterwards every address reads 0.
REQ-036 Reset during an in-flight READ_LATENCY=2 read -> no readValid pulse, readData=0.

Source files
------------

// File: rtl/dp_bram_clr_if.sv
// Request/response bundle for the dual-port byte-lane RAM with array clear.
// The master side issues reads/writes on both ports; the slave side is the RAM.
interface dp_bram_clr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  readEnable_1;
  logic                  writeEnable_1;
  logic [ADDR_WIDTH-1:0] address_1;
  logic [DATA_WIDTH-1:0] writeData_1;
  logic [BE_WIDTH-1:0]   byteEnable_1;
  logic [DATA_WIDTH-1:0] readData_1;
  logic                  readValid_1;

  logic                  readEnable_2;
  logic                  writeEnable_2;
  logic [ADDR_WIDTH-1:0] address_2;
  logic [DATA_WIDTH-1:0] writeData_2;
  logic [BE_WIDTH-1:0]   byteEnable_2;
  logic [DATA_WIDTH-1:0] readData_2;
  logic                  readValid_2;

  logic                  collision;
  logic                  busy;

  modport master (
    output readEnable_1, writeEnable_1, address_1, writeData_1, byteEnable_1,
    output readEnable_2, writeEnable_2, address_2, writeData_2, byteEnable_2,
    input  readData_1, readValid_1, readData_2, readValid_2, collision, busy
  );

  modport slave (
    input  readEnable_1, writeEnable_1, address_1, writeData_1, byteEnable_1,
    input  readEnable_2, writeEnable_2, address_2, writeData_2, byteEnable_2,
    output readData_1, readValid_1, readData_2, readValid_2, collision, busy
  );
endinterface

// File: rtl/dp_bram_clr.sv
// True dual-port RAM with byte-lane writes, per-port read-during-write mode,
// lane-level write priority, 1- or 2-stage read pipeline and an optional post-reset clear.
module dp_bram_clr #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE_1   = 1,
  parameter int WRITE_MODE_2   = 1,
  parameter int PRIORITY_PORT  = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input logic         clock,
  input logic         reset,
  dp_bram_clr_if.slave bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [LANES-1:0]      lane_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 ||
      (READ_LATENCY != 1 && READ_LATENCY != 2) ||
      (PRIORITY_PORT != 1 && PRIORITY_PORT != 2) || CORE < 0) begin : g_bad_params
    $fatal(1, "dp_bram_clr: illegal parameter value");
  end

  function automatic word_t lane_merge(word_t old_w, word_t new_w, lane_t be);
    word_t r;
    r = old_w;
    for (int l = 0; l < LANES; l++) begin
      if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    end
    return r;
  endfunction

  state_t state;
  addr_t  clr_addr;
  logic   busy_q;
  logic   collision_q;
  word_t  mem [DEPTH];

  // Port requests only take effect in IDLE and outside reset.
  logic  port_ok;
  logic  rd_1, wr_1, rd_2, wr_2;
  lane_t overlap, mask_1, mask_2;
  word_t rd_word_1, rd_word_2;

  assign port_ok = (state == IDLE) && !reset;
  assign rd_1    = port_ok && bus.readEnable_1;
  assign wr_1    = port_ok && bus.writeEnable_1;
  assign rd_2    = port_ok && bus.readEnable_2;
  assign wr_2    = port_ok && bus.writeEnable_2;

  // NOTE: every always_comb output gets a default before any conditional
  // override, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    overlap = '0;
    if (wr_1 && wr_2 && (bus.address_1 == bus.address_2))
      overlap = bus.byteEnable_1 & bus.byteEnable_2;
    mask_1 = wr_1 ? bus.byteEnable_1 : '0;
    mask_2 = wr_2 ? bus.byteEnable_2 : '0;
    if (PRIORITY_PORT == 1) mask_2 = mask_2 & ~overlap;
    else                    mask_1 = mask_1 & ~overlap;
  end

  // A same-port write is always to the read address, so write-first just merges
  // that port's own lanes; the other port's write is never visible this cycle.
  always_comb begin
    rd_word_1 = mem[bus.address_1];
    if (WRITE_MODE_1 == 1 && wr_1)
      rd_word_1 = lane_merge(rd_word_1, bus.writeData_1, bus.byteEnable_1);
    rd_word_2 = mem[bus.address_2];
    if (WRITE_MODE_2 == 1 && wr_2)
      rd_word_2 = lane_merge(rd_word_2, bus.writeData_2, bus.byteEnable_2);
  end

  // NOTE: the array has no reset branch so it maps onto block RAM; zeroing is
  // done by the CLEAR state one word per cycle instead.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (mask_1[l]) mem[bus.address_1][l*8 +: 8] <= bus.writeData_1[l*8 +: 8];
        if (mask_2[l]) mem[bus.address_2][l*8 +: 8] <= bus.writeData_2[l*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr    <= '0;
      busy_q      <= (CLEAR_ON_RESET != 0);
      collision_q <= 1'b0;
    end else begin
      collision_q <= |overlap;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
        end
        CLEAR: begin
          if (&clr_addr) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + addr_t'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // First read stage: data only loads when a read is accepted, so it holds otherwise.
  logic  s1_valid_1, s1_valid_2;
  word_t s1_data_1, s1_data_2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_1 <= 1'b0;
      s1_valid_2 <= 1'b0;
      s1_data_1  <= '0;
      s1_data_2  <= '0;
    end else begin
      s1_valid_1 <= rd_1;
      s1_valid_2 <= rd_2;
      if (rd_1) s1_data_1 <= rd_word_1;
      if (rd_2) s1_data_2 <= rd_word_2;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic  s2_valid_1, s2_valid_2;
    word_t s2_data_1, s2_data_2;

    always_ff @(posedge clock) begin
      if (reset) begin
        s2_valid_1 <= 1'b0;
        s2_valid_2 <= 1'b0;
        s2_data_1  <= '0;
        s2_data_2  <= '0;
      end else begin
        s2_valid_1 <= s1_valid_1;
        s2_valid_2 <= s1_valid_2;
        if (s1_valid_1) s2_data_1 <= s1_data_1;
        if (s1_valid_2) s2_data_2 <= s1_data_2;
      end
    end

    assign bus.readData_1  = s2_data_1;
    assign bus.readValid_1 = s2_valid_1;
    assign bus.readData_2  = s2_data_2;
    assign bus.readValid_2 = s2_valid_2;
  end else begin : g_lat1
    assign bus.readData_1  = s1_data_1;
    assign bus.readValid_1 = s1_valid_1;
    assign bus.readData_2  = s1_data_2;
    assign bus.readValid_2 = s1_valid_2;
  end

  assign bus.collision = collision_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dp_bram_clr.sv
// Directed bench for dp_bram_clr: instance A (latency 2, port-1 read-first, port 2 wins,
// clear on reset) and instance B (latency 1, write-first, port 1 wins, no clear).
module tb_dp_bram_clr;

  logic clock = 1'b0;
  logic reset_a, reset_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  dp_bram_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_a ();
  dp_bram_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_b ();

  dp_bram_clr #(
    .CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2),
    .WRITE_MODE_1(0), .WRITE_MODE_2(1), .PRIORITY_PORT(2), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset(reset_a), .bus(bus_a)
  );

  dp_bram_clr #(
    .CORE(1), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1),
    .WRITE_MODE_1(1), .WRITE_MODE_2(1), .PRIORITY_PORT(1), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clock(clock), .reset(reset_b), .bus(bus_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    bus_a.readEnable_1 = 0; bus_a.writeEnable_1 = 0; bus_a.address_1 = '0;
    bus_a.writeData_1  = '0; bus_a.byteEnable_1 = '0;
    bus_a.readEnable_2 = 0; bus_a.writeEnable_2 = 0; bus_a.address_2 = '0;
    bus_a.writeData_2  = '0; bus_a.byteEnable_2 = '0;
  endtask

  task automatic idle_b();
    bus_b.readEnable_1 = 0; bus_b.writeEnable_1 = 0; bus_b.address_1 = '0;
    bus_b.writeData_1  = '0; bus_b.byteEnable_1 = '0;
    bus_b.readEnable_2 = 0; bus_b.writeEnable_2 = 0; bus_b.address_2 = '0;
    bus_b.writeData_2  = '0; bus_b.byteEnable_2 = '0;
  endtask

  task automatic test_reset();
    logic exp_busy;
    reset_a = 1; reset_b = 1;
    tick();
    n_cmp++;
    if ({bus_a.readData_1, bus_a.readData_2, bus_a.readValid_1, bus_a.readValid_2,
         bus_a.collision, bus_a.busy} !== {32'h0, 32'h0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset_outputs_a: got %h expected %h",
               {bus_a.readData_1, bus_a.readData_2, bus_a.readValid_1, bus_a.readValid_2,
                bus_a.collision, bus_a.busy}, {32'h0, 32'h0, 4'b0001});
    end
    n_cmp++;
    if ({bus_b.readData_1, bus_b.readData_2, bus_b.readValid_1, bus_b.readValid_2,
         bus_b.collision, bus_b.busy} !== {32'h0, 32'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_outputs_b: got %h expected %h",
               {bus_b.readData_1, bus_b.readData_2, bus_b.readValid_1, bus_b.readValid_2,
                bus_b.collision, bus_b.busy}, {32'h0, 32'h0, 4'b0000});
    end
    reset_a = 0; reset_b = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_busy = (i < 16);
      n_cmp++;
      if (bus_a.busy !== exp_busy) begin
        n_bad++;
        $display("FAIL initial_clear_busy cycle %0d: got %b expected %b", i, bus_a.busy, exp_busy);
      end
    end
  endtask

  task automatic test_write_read();
    bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd3;
    bus_a.writeData_1 = 32'hDEADBEEF; bus_a.byteEnable_1 = 4'hF;
    tick(); idle_a();
    bus_a.readEnable_2 = 1; bus_a.address_2 = 4'd3;
    tick(); idle_a();
    n_cmp++;
    if (bus_a.readValid_2 !== 1'b0) begin
      n_bad++;
      $display("FAIL lat2_early_valid: got %b expected 0", bus_a.readValid_2);
    end
    tick();
    n_cmp++;
    if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b1, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL lat2_read: got %h expected %h", {bus_a.readValid_2, bus_a.readData_2},
               {1'b1, 32'hDEADBEEF});
    end
    tick();
    n_cmp++;
    if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL read_hold: got %h expected %h", {bus_a.readValid_2, bus_a.readData_2},
               {1'b0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_byte_enable();
    bus_b.writeEnable_1 = 1; bus_b.address_1 = 4'd5;
    bus_b.writeData_1 = 32'h11223344; bus_b.byteEnable_1 = 4'hF;
    tick();
    bus_b.writeData_1 = 32'hAABBCCDD; bus_b.byteEnable_1 = 4'b0101;
    tick();
    bus_b.writeData_1 = 32'hFFFFFFFF; bus_b.byteEnable_1 = 4'b0000;
    tick(); idle_b();
    bus_b.readEnable_1 = 1; bus_b.address_1 = 4'd5;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.readValid_1, bus_b.readData_1} !== {1'b1, 32'h11BB33DD}) begin
      n_bad++;
      $display("FAIL byte_lanes: got %h expected %h", {bus_b.readValid_1, bus_b.readData_1},
               {1'b1, 32'h11BB33DD});
    end
    tick();
    n_cmp++;
    if (bus_b.readValid_1 !== 1'b0) begin
      n_bad++;
      $display("FAIL lat1_single_pulse: got %b expected 0", bus_b.readValid_1);
    end
  endtask

  task automatic test_collision();
    // Instance A: port 2 wins overlapping lane 0.
    bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd7;
    bus_a.writeData_1 = 32'h00000011; bus_a.byteEnable_1 = 4'b0011;
    bus_a.writeEnable_2 = 1; bus_a.address_2 = 4'd7;
    bus_a.writeData_2 = 32'h22000022; bus_a.byteEnable_2 = 4'b1001;
    tick(); idle_a();
    n_cmp++;
    if (bus_a.collision !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_a_pulse: got %b expected 1", bus_a.collision);
    end
    bus_a.readEnable_1 = 1; bus_a.address_1 = 4'd7;
    tick(); idle_a();
    n_cmp++;
    if (bus_a.collision !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_a_clear: got %b expected 0", bus_a.collision);
    end
    tick();
    n_cmp++;
    if ({bus_a.readValid_1, bus_a.readData_1} !== {1'b1, 32'h22000022}) begin
      n_bad++;
      $display("FAIL priority2_word: got %h expected %h", {bus_a.readValid_1, bus_a.readData_1},
               {1'b1, 32'h22000022});
    end
    // Instance B: port 1 wins overlapping lane 0.
    bus_b.writeEnable_2 = 1; bus_b.address_2 = 4'd7; bus_b.writeData_2 = '0; bus_b.byteEnable_2 = 4'hF;
    tick(); idle_b();
    bus_b.writeEnable_1 = 1; bus_b.address_1 = 4'd7;
    bus_b.writeData_1 = 32'h00000011; bus_b.byteEnable_1 = 4'b0011;
    bus_b.writeEnable_2 = 1; bus_b.address_2 = 4'd7;
    bus_b.writeData_2 = 32'h22000022; bus_b.byteEnable_2 = 4'b1001;
    tick(); idle_b();
    n_cmp++;
    if (bus_b.collision !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_b_pulse: got %b expected 1", bus_b.collision);
    end
    bus_b.readEnable_2 = 1; bus_b.address_2 = 4'd7;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.collision, bus_b.readValid_2, bus_b.readData_2} !== {2'b01, 32'h22000011}) begin
      n_bad++;
      $display("FAIL priority1_word: got %h expected %h",
               {bus_b.collision, bus_b.readValid_2, bus_b.readData_2}, {2'b01, 32'h22000011});
    end
    // Same address, disjoint lanes: both land, no collision.
    bus_b.writeEnable_1 = 1; bus_b.address_1 = 4'd8;
    bus_b.writeData_1 = 32'h00005566; bus_b.byteEnable_1 = 4'b0011;
    bus_b.writeEnable_2 = 1; bus_b.address_2 = 4'd8;
    bus_b.writeData_2 = 32'h77880000; bus_b.byteEnable_2 = 4'b1100;
    tick(); idle_b();
    bus_b.readEnable_1 = 1; bus_b.address_1 = 4'd8;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.collision, bus_b.readValid_1, bus_b.readData_1} !== {2'b01, 32'h77885566}) begin
      n_bad++;
      $display("FAIL disjoint_lanes: got %h expected %h",
               {bus_b.collision, bus_b.readValid_1, bus_b.readData_1}, {2'b01, 32'h77885566});
    end
    // Overlapping lanes, different addresses: no collision.
    bus_b.writeEnable_1 = 1; bus_b.address_1 = 4'd9;  bus_b.writeData_1 = 32'h1; bus_b.byteEnable_1 = 4'hF;
    bus_b.writeEnable_2 = 1; bus_b.address_2 = 4'd10; bus_b.writeData_2 = 32'h2; bus_b.byteEnable_2 = 4'hF;
    tick(); idle_b();
    n_cmp++;
    if (bus_b.collision !== 1'b0) begin
      n_bad++;
      $display("FAIL diff_addr_collision: got %b expected 0", bus_b.collision);
    end
  endtask

  task automatic test_read_during_write();
    // A port 1 is read-first.
    bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd2; bus_a.writeData_1 = 32'h5; bus_a.byteEnable_1 = 4'hF;
    tick();
    bus_a.readEnable_1 = 1; bus_a.writeData_1 = 32'h9;
    tick(); idle_a();
    tick();
    n_cmp++;
    if ({bus_a.readValid_1, bus_a.readData_1} !== {1'b1, 32'h5}) begin
      n_bad++;
      $display("FAIL read_first: got %h expected %h", {bus_a.readValid_1, bus_a.readData_1}, {1'b1, 32'h5});
    end
    bus_a.readEnable_1 = 1; bus_a.address_1 = 4'd2;
    tick(); idle_a();
    tick();
    n_cmp++;
    if ({bus_a.readValid_1, bus_a.readData_1} !== {1'b1, 32'h9}) begin
      n_bad++;
      $display("FAIL read_first_after: got %h expected %h", {bus_a.readValid_1, bus_a.readData_1}, {1'b1, 32'h9});
    end
    // A port 2 is write-first; addr 6 still holds zero from the clear.
    bus_a.readEnable_2 = 1; bus_a.writeEnable_2 = 1; bus_a.address_2 = 4'd6;
    bus_a.writeData_2 = 32'h77; bus_a.byteEnable_2 = 4'hF;
    tick(); idle_a();
    tick();
    n_cmp++;
    if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b1, 32'h77}) begin
      n_bad++;
      $display("FAIL write_first_a2: got %h expected %h", {bus_a.readValid_2, bus_a.readData_2}, {1'b1, 32'h77});
    end
    // B port 1 is write-first.
    bus_b.writeEnable_1 = 1; bus_b.address_1 = 4'd2; bus_b.writeData_1 = 32'h5; bus_b.byteEnable_1 = 4'hF;
    tick();
    bus_b.readEnable_1 = 1; bus_b.writeData_1 = 32'h9;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.readValid_1, bus_b.readData_1} !== {1'b1, 32'h9}) begin
      n_bad++;
      $display("FAIL write_first: got %h expected %h", {bus_b.readValid_1, bus_b.readData_1}, {1'b1, 32'h9});
    end
    // Read on port 1 while port 2 writes the same word: old word returned.
    bus_b.readEnable_1 = 1; bus_b.address_1 = 4'd2;
    bus_b.writeEnable_2 = 1; bus_b.address_2 = 4'd2; bus_b.writeData_2 = 32'hAB; bus_b.byteEnable_2 = 4'hF;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.readValid_1, bus_b.readData_1} !== {1'b1, 32'h9}) begin
      n_bad++;
      $display("FAIL cross_port_old: got %h expected %h", {bus_b.readValid_1, bus_b.readData_1}, {1'b1, 32'h9});
    end
    bus_b.readEnable_1 = 1; bus_b.address_1 = 4'd2;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.readValid_1, bus_b.readData_1} !== {1'b1, 32'hAB}) begin
      n_bad++;
      $display("FAIL cross_port_new: got %h expected %h", {bus_b.readValid_1, bus_b.readData_1}, {1'b1, 32'hAB});
    end
  endtask

  task automatic test_clear();
    logic exp_busy;
    bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd0;  bus_a.writeData_1 = 32'h01010101; bus_a.byteEnable_1 = 4'hF;
    bus_a.writeEnable_2 = 1; bus_a.address_2 = 4'd15; bus_a.writeData_2 = 32'hF0F0F0F0; bus_a.byteEnable_2 = 4'hF;
    tick(); idle_a();
    reset_a = 1;
    tick();
    reset_a = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++;
      if (bus_a.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL clear_busy_first cycle %0d: got %b expected 1", i, bus_a.busy);
      end
    end
    reset_a = 1;
    tick();
    reset_a = 0;
    // Requests on both ports during the clear must have no effect at all.
    bus_a.readEnable_1 = 1; bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd4;
    bus_a.writeData_1 = 32'hFFFFFFFF; bus_a.byteEnable_1 = 4'hF;
    bus_a.readEnable_2 = 1; bus_a.writeEnable_2 = 1; bus_a.address_2 = 4'd4;
    bus_a.writeData_2 = 32'hEEEEEEEE; bus_a.byteEnable_2 = 4'hF;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_busy = (i < 16);
      n_cmp++;
      if ({bus_a.readValid_1, bus_a.readValid_2, bus_a.collision, bus_a.busy} !== {3'b000, exp_busy}) begin
        n_bad++;
        $display("FAIL clear_restart cycle %0d: got %b expected %b", i,
                 {bus_a.readValid_1, bus_a.readValid_2, bus_a.collision, bus_a.busy}, {3'b000, exp_busy});
      end
    end
    idle_a();
    for (int a = 0; a < 16; a++) begin
      bus_a.readEnable_2 = 1; bus_a.address_2 = 4'(a);
      tick(); idle_a();
      tick();
      n_cmp++;
      if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b1, 32'h0}) begin
        n_bad++;
        $display("FAIL cleared_word addr %0d: got %h expected %h", a,
                 {bus_a.readValid_2, bus_a.readData_2}, {1'b1, 32'h0});
      end
    end
  endtask

  task automatic test_reset_inflight();
    bus_a.writeEnable_1 = 1; bus_a.address_1 = 4'd3; bus_a.writeData_1 = 32'hDEADBEEF; bus_a.byteEnable_1 = 4'hF;
    tick(); idle_a();
    bus_a.readEnable_2 = 1; bus_a.address_2 = 4'd3;
    tick(); idle_a();
    tick();
    n_cmp++;
    if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b1, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL inflight_setup: got %h expected %h", {bus_a.readValid_2, bus_a.readData_2},
               {1'b1, 32'hDEADBEEF});
    end
    bus_a.readEnable_2 = 1; bus_a.address_2 = 4'd3;
    tick(); idle_a();
    reset_a = 1;
    tick();
    reset_a = 0;
    n_cmp++;
    if ({bus_a.readValid_2, bus_a.readData_2} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL inflight_flush: got %h expected %h", {bus_a.readValid_2, bus_a.readData_2}, {1'b0, 32'h0});
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++;
      if ({bus_a.readValid_2, bus_a.busy} !== {1'b0, (i < 16)}) begin
        n_bad++;
        $display("FAIL inflight_after cycle %0d: got %b expected %b", i,
                 {bus_a.readValid_2, bus_a.busy}, {1'b0, (i < 16)});
      end
    end
  endtask

  task automatic test_reset_keep();
    reset_b = 1;
    tick();
    reset_b = 0;
    n_cmp++;
    if ({bus_b.busy, bus_b.readValid_1, bus_b.readData_1} !== {2'b00, 32'h0}) begin
      n_bad++;
      $display("FAIL keep_reset_state: got %h expected %h",
               {bus_b.busy, bus_b.readValid_1, bus_b.readData_1}, {2'b00, 32'h0});
    end
    bus_b.readEnable_1 = 1; bus_b.address_1 = 4'd5;
    bus_b.readEnable_2 = 1; bus_b.address_2 = 4'd7;
    tick(); idle_b();
    n_cmp++;
    if ({bus_b.readValid_1, bus_b.readData_1, bus_b.readValid_2, bus_b.readData_2} !==
        {1'b1, 32'h11BB33DD, 1'b1, 32'h22000011}) begin
      n_bad++;
      $display("FAIL keep_contents: got %h expected %h",
               {bus_b.readValid_1, bus_b.readData_1, bus_b.readValid_2, bus_b.readData_2},
               {1'b1, 32'h11BB33DD, 1'b1, 32'h22000011});
    end
  endtask

  initial begin
    idle_a();
    idle_b();
    reset_a = 1;
    reset_b = 1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_read_during_write();
    test_clear();
    test_reset_inflight();
    test_reset_keep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
